// File: rtl/fnmadd_mul_stage_if.sv
// Handshake bundle between operand unpack, the FNMADD multiply stage
// and the align/add stage.
interface fnmadd_mul_stage_if #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     a_sign;
    logic                     b_sign;
    logic                     c_sign;
    logic [EXP_WIDTH-1:0]     a_exp;
    logic [EXP_WIDTH-1:0]     b_exp;
    logic [EXP_WIDTH-1:0]     c_exp;
    logic [SIG_WIDTH:0]       a_sig;
    logic [SIG_WIDTH:0]       b_sig;
    logic [SIG_WIDTH:0]       c_sig;
    logic                     a_sub;
    logic                     b_sub;
    logic                     c_sub;
    logic                     out_valid;
    logic                     out_ready;
    logic                     p_sign;
    logic [EXP_WIDTH+1:0]     p_exp;
    logic [2*SIG_WIDTH+1:0]   p_sig;
    logic                     p_zero;
    logic                     p_special;
    logic                     c_sign_o;
    logic [EXP_WIDTH-1:0]     c_exp_o;
    logic [SIG_WIDTH:0]       c_sig_o;
    logic                     c_sub_o;

    modport slave (
        input  in_valid, a_sign, b_sign, c_sign,
        input  a_exp, b_exp, c_exp,
        input  a_sig, b_sig, c_sig,
        input  a_sub, b_sub, c_sub, out_ready,
        output in_ready, out_valid, p_sign, p_exp,
        output p_sig, p_zero, p_special,
        output c_sign_o, c_exp_o, c_sig_o, c_sub_o
    );

    modport master (
        output in_valid, a_sign, b_sign, c_sign,
        output a_exp, b_exp, c_exp,
        output a_sig, b_sig, c_sig,
        output a_sub, b_sub, c_sub, out_ready,
        input  in_ready, out_valid, p_sign, p_exp,
        input  p_sig, p_zero, p_special,
        input  c_sign_o, c_exp_o, c_sig_o, c_sub_o
    );
endinterface

// File: rtl/fnmadd_mul_stage.sv
// FNMADD multiply stage: radix-2 shift-add significand product of A*B,
// product exponent, negated signs and registered C pass-through.
module fnmadd_mul_stage #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 23,
    parameter int BIAS      = 127
) (
    input  logic clk,
    input  logic rst_n,
    fnmadd_mul_stage_if.slave bus
);
    localparam int EW = EXP_WIDTH + 2;
    localparam int PW = 2 * SIG_WIDTH + 2;
    localparam int CW = $clog2(SIG_WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(SIG_WIDTH);

    if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("fnmadd_mul_stage: WIDTH must be 32 or 64");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 p_sign_q, p_sign_d;
    logic [EW-1:0]        p_exp_q, p_exp_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic                 p_zero_q, p_zero_d;
    logic                 p_special_q, p_special_d;
    logic                 c_sign_q, c_sign_d;
    logic [EXP_WIDTH-1:0] c_exp_q, c_exp_d;
    logic [SIG_WIDTH:0]   c_sig_q, c_sig_d;
    logic                 c_sub_q, c_sub_d;
    logic [PW-1:0]        mcand_q, mcand_d;
    logic [SIG_WIDTH:0]   mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 a_zero, b_zero;
    logic [EXP_WIDTH-1:0] a_eff_exp, b_eff_exp;
    logic [SIG_WIDTH:0]   a_eff_sig, b_eff_sig;

    // Operand classification; the hidden bit is not trusted for zeros
    always_comb begin
        a_zero = (bus.a_exp == '0)
               && (bus.a_sig[SIG_WIDTH-1:0] == '0);
        b_zero = (bus.b_exp == '0)
               && (bus.b_sig[SIG_WIDTH-1:0] == '0);
        a_eff_exp = (bus.a_exp == '0) ? EXP_WIDTH'(1) : bus.a_exp;
        b_eff_exp = (bus.b_exp == '0) ? EXP_WIDTH'(1) : bus.b_exp;
        a_eff_sig = {bus.a_sig[SIG_WIDTH] & ~bus.a_sub,
                     bus.a_sig[SIG_WIDTH-1:0]};
        b_eff_sig = {bus.b_sig[SIG_WIDTH] & ~bus.b_sub,
                     bus.b_sig[SIG_WIDTH-1:0]};
    end

    // Next-state, datapath and handshake outputs
    always_comb begin
        state_d     = state_q;
        p_sign_d    = p_sign_q;
        p_exp_d     = p_exp_q;
        acc_d       = acc_q;
        p_zero_d    = p_zero_q;
        p_special_d = p_special_q;
        c_sign_d    = c_sign_q;
        c_exp_d     = c_exp_q;
        c_sig_d     = c_sig_q;
        c_sub_d     = c_sub_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    p_sign_d    = ~(bus.a_sign ^ bus.b_sign);
                    p_exp_d     = EW'(a_eff_exp) + EW'(b_eff_exp)
                                - EW'(BIAS);
                    p_special_d = (&bus.a_exp) | (&bus.b_exp)
                                | (&bus.c_exp);
                    c_sign_d    = ~bus.c_sign;
                    c_exp_d     = bus.c_exp;
                    c_sig_d     = bus.c_sig;
                    c_sub_d     = bus.c_sub;
                    acc_d       = '0;
                    cnt_d       = '0;
                    mcand_d     = PW'(a_eff_sig);
                    mplier_d    = b_eff_sig;
                    if (a_zero || b_zero) begin
                        p_zero_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        p_zero_d = 1'b0;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers, cleared by async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            p_sign_q    <= 1'b0;
            p_exp_q     <= '0;
            acc_q       <= '0;
            p_zero_q    <= 1'b0;
            p_special_q <= 1'b0;
            c_sign_q    <= 1'b0;
            c_exp_q     <= '0;
            c_sig_q     <= '0;
            c_sub_q     <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            p_sign_q    <= p_sign_d;
            p_exp_q     <= p_exp_d;
            acc_q       <= acc_d;
            p_zero_q    <= p_zero_d;
            p_special_q <= p_special_d;
            c_sign_q    <= c_sign_d;
            c_exp_q     <= c_exp_d;
            c_sig_q     <= c_sig_d;
            c_sub_q     <= c_sub_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p_sign    = p_sign_q;
    assign bus.p_exp     = p_exp_q;
    assign bus.p_sig     = acc_q;
    assign bus.p_zero    = p_zero_q;
    assign bus.p_special = p_special_q;
    assign bus.c_sign_o  = c_sign_q;
    assign bus.c_exp_o   = c_exp_q;
    assign bus.c_sig_o   = c_sig_q;
    assign bus.c_sub_o   = c_sub_q;
endmodule

// File: tb/tb_fnmadd_mul_stage.sv
// Testbench for fnmadd_mul_stage: vector table, random model ops,
// backpressure and mid-operation reset sequences.
module tb_fnmadd_mul_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fnmadd_mul_stage_if #(.EXP_WIDTH(8), .SIG_WIDTH(23)) bus ();

    fnmadd_mul_stage #(
        .WIDTH(32), .EXP_WIDTH(8), .SIG_WIDTH(23), .BIAS(127)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic as; logic [7:0] ae; logic [23:0] asg; logic asb;
        logic bs; logic [7:0] be; logic [23:0] bsg; logic bsb;
        logic cs; logic [7:0] ce; logic [23:0] csg; logic csb;
    } in_t;

    typedef struct {
        logic ps; logic [9:0] pe; logic [47:0] psig;
        logic pz; logic psp;
        logic cs; logic [7:0] ce; logic [23:0] csg; logic csb;
        int lat;
    } exp_t;

    typedef struct { in_t i; exp_t e; } vec_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   n_vec = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic in_t mki(
        logic as, logic [7:0] ae, logic [23:0] asg, logic asb,
        logic bs, logic [7:0] be, logic [23:0] bsg, logic bsb,
        logic cs, logic [7:0] ce, logic [23:0] csg, logic csb);
        in_t r;
        r.as = as; r.ae = ae; r.asg = asg; r.asb = asb;
        r.bs = bs; r.be = be; r.bsg = bsg; r.bsb = bsb;
        r.cs = cs; r.ce = ce; r.csg = csg; r.csb = csb;
        return r;
    endfunction

    function automatic vec_t mkv(in_t i, logic ps, logic [9:0] pe,
                                 logic [47:0] psig, logic pz,
                                 logic psp);
        vec_t v;
        v.i = i;
        v.e.ps = ps; v.e.pe = pe; v.e.psig = psig;
        v.e.pz = pz; v.e.psp = psp;
        v.e.cs = ~i.cs; v.e.ce = i.ce;
        v.e.csg = i.csg; v.e.csb = i.csb;
        v.e.lat = pz ? 0 : 24;
        return v;
    endfunction

    function automatic exp_t model(in_t i);
        exp_t e;
        logic az, bz;
        int ea, eb;
        az = (i.ae == 0) && (i.asg[22:0] == 0);
        bz = (i.be == 0) && (i.bsg[22:0] == 0);
        ea = (i.ae == 0) ? 1 : int'(i.ae);
        eb = (i.be == 0) ? 1 : int'(i.be);
        e.ps = ~(i.as ^ i.bs);
        e.pe = 10'(ea + eb - 127);
        e.psig = (az || bz) ? 48'h0 : 48'(i.asg) * 48'(i.bsg);
        e.pz = az || bz;
        e.psp = (i.ae == 8'hFF) || (i.be == 8'hFF) || (i.ce == 8'hFF);
        e.cs = ~i.cs; e.ce = i.ce; e.csg = i.csg; e.csb = i.csb;
        e.lat = e.pz ? 0 : 24;
        return e;
    endfunction

    task automatic drive(input in_t i, input logic v);
        bus.in_valid = v;
        bus.a_sign = i.as; bus.a_exp = i.ae;
        bus.a_sig = i.asg; bus.a_sub = i.asb;
        bus.b_sign = i.bs; bus.b_exp = i.be;
        bus.b_sig = i.bsg; bus.b_sub = i.bsb;
        bus.c_sign = i.cs; bus.c_exp = i.ce;
        bus.c_sig = i.csg; bus.c_sub = i.csb;
    endtask

    task automatic send(input in_t i, input exp_t e);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        drive(i, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(e);
        n_vec++;
    endtask

    task automatic finish_op(input int hold, input in_t junk);
        exp_t e;
        int lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb[0];
        chk("latency", 64'(lat), 64'(e.lat));
        for (int k = 0; k < hold; k++) begin
            if (k == 3) drive(junk, 1'b1);
            if (k == 4) bus.in_valid = 1'b0;
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_p_sig", 64'(bus.p_sig), 64'(e.psig));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        chk("p_sign", 64'(bus.p_sign), 64'(e.ps));
        chk("p_exp", 64'(bus.p_exp), 64'(e.pe));
        chk("p_sig", 64'(bus.p_sig), 64'(e.psig));
        chk("p_zero", 64'(bus.p_zero), 64'(e.pz));
        chk("p_special", 64'(bus.p_special), 64'(e.psp));
        chk("c_sign_o", 64'(bus.c_sign_o), 64'(e.cs));
        chk("c_exp_o", 64'(bus.c_exp_o), 64'(e.ce));
        chk("c_sig_o", 64'(bus.c_sig_o), 64'(e.csg));
        chk("c_sub_o", 64'(bus.c_sub_o), 64'(e.csb));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_out_valid", 64'(bus.out_valid), 64'd0);
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic run_op(input vec_t v, input int hold);
        in_t junk;
        junk = mki(1, 8'h10, 24'h900000, 0, 1, 8'h20, 24'hA00000, 0,
                   0, 8'h30, 24'hB00000, 1);
        send(v.i, v.e);
        finish_op(hold, junk);
    endtask

    in_t one, zro, ri;
    vec_t rv;

    initial begin
        bus.out_ready = 1'b0;
        zro = mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(zro, 1'b0);
        one = mki(0, 127, 24'h800000, 0, 0, 127, 24'h800000, 0,
                  0, 127, 24'h800000, 0);
        tbl[0] = mkv(one, 1, 10'd127, 48'h400000000000, 0, 0);
        tbl[1] = mkv(mki(0, 127, 24'hC00000, 0, 1, 128, 24'h800000, 0,
                         0, 100, 24'h900000, 0),
                     0, 10'd128, 48'h600000000000, 0, 0);
        tbl[2] = mkv(mki(0, 0, 24'h800000, 0, 0, 128, 24'hC00000, 0,
                         0, 127, 24'h800000, 0),
                     1, 10'd2, 48'h0, 1, 0);
        tbl[3] = mkv(mki(0, 0, 24'h000001, 1, 0, 127, 24'h800000, 0,
                         1, 129, 24'hA00000, 0),
                     1, 10'd1, 48'h000000800000, 0, 0);
        tbl[4] = mkv(mki(1, 255, 24'hC00000, 0, 1, 127, 24'h800000, 0,
                         0, 1, 24'h800000, 0),
                     1, 10'd255, 48'h600000000000, 0, 1);
        tbl[5] = mkv(mki(1, 254, 24'hFFFFFF, 0, 0, 254, 24'hFFFFFF, 0,
                         0, 255, 24'h800000, 0),
                     0, 10'h17D, 48'hFFFFFE000001, 0, 1);
        tbl[6] = mkv(mki(0, 1, 24'h800000, 0, 0, 1, 24'h800000, 0,
                         1, 2, 24'h812345, 0),
                     1, 10'h383, 48'h400000000000, 0, 0);
        tbl[7] = mkv(mki(0, 200, 24'h812345, 0, 0, 0, 24'h800000, 0,
                         1, 0, 24'h000123, 1),
                     1, 10'd74, 48'h0, 1, 0);
        tbl[8] = mkv(mki(1, 0, 24'h000003, 1, 1, 0, 24'h000005, 1,
                         0, 3, 24'h800000, 0),
                     1, 10'h383, 48'h00000000000F, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_p_sig", 64'(bus.p_sig), 64'd0);
        chk("rst_p_exp", 64'(bus.p_exp), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

        for (int k = 0; k < 9; k++) run_op(tbl[k], 0);

        for (int k = 0; k < 8; k++) begin
            ri.as = 1'($urandom); ri.bs = 1'($urandom);
            ri.cs = 1'($urandom);
            ri.ae = 8'($urandom_range(1, 254));
            ri.be = 8'($urandom_range(1, 254));
            ri.ce = 8'($urandom_range(0, 255));
            ri.asg = {1'b1, 23'($urandom)};
            ri.bsg = {1'b1, 23'($urandom)};
            ri.csg = {1'b1, 23'($urandom)};
            ri.asb = 0; ri.bsb = 0; ri.csb = 0;
            if (k % 3 == 1) begin
                ri.ae = 0; ri.asb = 1;
                ri.asg = {1'b0, 23'($urandom)};
            end
            rv.i = ri;
            rv.e = model(ri);
            run_op(rv, 0);
        end

        run_op(tbl[1], 10);
        run_op(tbl[3], 0);

        send(tbl[5].i, tbl[5].e);
        repeat (9) @(posedge clk);
        #1;
        chk("mid_busy", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        chk("abort_p_sig", 64'(bus.p_sig), 64'd0);
        chk("abort_p_exp", 64'(bus.p_exp), 64'd0);
        chk("abort_p_sign", 64'(bus.p_sign), 64'd0);
        chk("abort_c_exp", 64'(bus.c_exp_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_rel_valid", 64'(bus.out_valid), 64'd0);
        run_op(tbl[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
